// File: rtl/ssd1306_spi_receiver_pkg.sv
// Shared opcode table, reset defaults and encodings for the SSD1306 display-side SPI receiver.
package ssd1306_spi_receiver_pkg;

   localparam logic [7:0] OP_DISPLAY_OFF   = 8'hAE;
   localparam logic [7:0] OP_DISPLAY_ON    = 8'hAF;
   localparam logic [7:0] OP_RESUME_RAM    = 8'hA4;
   localparam logic [7:0] OP_ENTIRE_ON     = 8'hA5;
   localparam logic [7:0] OP_NORMAL        = 8'hA6;
   localparam logic [7:0] OP_INVERSE       = 8'hA7;
   localparam logic [7:0] OP_SEG_REMAP0    = 8'hA0;
   localparam logic [7:0] OP_SEG_REMAP1    = 8'hA1;
   localparam logic [7:0] OP_COM_SCAN_INC  = 8'hC0;
   localparam logic [7:0] OP_COM_SCAN_DEC  = 8'hC8;
   localparam logic [7:0] OP_CONTRAST      = 8'h81;
   localparam logic [7:0] OP_ADDR_MODE     = 8'h20;
   localparam logic [7:0] OP_MUX_RATIO     = 8'hA8;
   localparam logic [7:0] OP_DISP_OFFSET   = 8'hD3;
   localparam logic [7:0] OP_CLK_DIV       = 8'hD5;
   localparam logic [7:0] OP_PRECHARGE     = 8'hD9;
   localparam logic [7:0] OP_VCOMH         = 8'hDB;
   localparam logic [7:0] OP_CHARGE_PUMP   = 8'h8D;
   localparam logic [7:0] OP_COL_ADDR      = 8'h21;
   localparam logic [7:0] OP_PAGE_ADDR     = 8'h22;

   localparam logic [1:0] ARGS_UNKNOWN     = 2'd3;

   localparam logic [7:0] CONTRAST_DEFAULT = 8'h7F;
   localparam logic [6:0] COL_END_DEFAULT  = 7'd127;
   localparam logic [2:0] PAGE_END_DEFAULT = 3'd7;

   localparam logic [1:0] AM_HORIZ         = 2'b00;
   localparam logic [1:0] AM_VERT          = 2'b01;
   localparam logic [1:0] AM_PAGE          = 2'b10;
   localparam logic [1:0] AM_PAGE_ALT      = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARG1 = 2'd1,
      ST_ARG2 = 2'd2
   } parse_state_t;

   // Number of argument bytes following an opcode; ARGS_UNKNOWN flags an unsupported opcode.
   function automatic logic [1:0] op_arg_count(input logic [7:0] op);
      logic [1:0] n;
      n = ARGS_UNKNOWN;
      case (op)
         OP_DISPLAY_OFF, OP_DISPLAY_ON, OP_RESUME_RAM, OP_ENTIRE_ON,
         OP_NORMAL, OP_INVERSE, OP_SEG_REMAP0, OP_SEG_REMAP1,
         OP_COM_SCAN_INC, OP_COM_SCAN_DEC:                          n = 2'd0;
         OP_CONTRAST, OP_ADDR_MODE, OP_MUX_RATIO, OP_DISP_OFFSET,
         OP_CLK_DIV, OP_PRECHARGE, OP_VCOMH, OP_CHARGE_PUMP:        n = 2'd1;
         OP_COL_ADDR, OP_PAGE_ADDR:                                 n = 2'd2;
         default: if (op[7:6] == 2'b01) n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/ssd1306_spi_receiver_spi_byte_rx.sv
// Synchronises the SPI pins and deserialises MSB-first bytes, tagging each with the dc level.
module spi_byte_rx
   import ssd1306_spi_receiver_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_sclk,
   input  logic       spi_sdin,
   input  logic       spi_cs,
   input  logic       spi_dc,
   input  logic       spi_reset,
   output logic       panel_rst,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       rx_dc
);

   // Pin bundle order {reset, dc, cs, sdin, sclk}; idle is reset released, cs high, sclk high.
   localparam logic [4:0] PIN_IDLE = 5'b10101;

   logic [4:0] pins;
   logic [4:0] sync_reg [SYNC_STAGES];
   logic [4:0] synced;

   assign pins = {spi_reset, spi_dc, spi_cs, spi_sdin, spi_sclk};

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (rst) sync_reg[gi] <= PIN_IDLE;
               else     sync_reg[gi] <= pins;
            end
         end else begin : g_next
            always_ff @(posedge clk) begin
               if (rst) sync_reg[gi] <= PIN_IDLE;
               else     sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   assign synced = sync_reg[SYNC_STAGES-1];

   logic       sclk_s, sdin_s, cs_s, dc_s;
   logic       sclk_prev_reg;
   logic       core_rst;
   logic       sclk_rise;
   logic [7:0] shift_reg;
   logic [7:0] shift_next;
   logic [2:0] bit_cnt_reg;

   assign sclk_s     = synced[0];
   assign sdin_s     = synced[1];
   assign cs_s       = synced[2];
   assign dc_s       = synced[3];
   assign panel_rst  = ~synced[4];
   assign core_rst   = rst | panel_rst;
   assign sclk_rise  = sclk_s & ~sclk_prev_reg;
   assign shift_next = {shift_reg[6:0], sdin_s};

   // Edge history follows the pin even during a panel reset so release never fakes a rise.
   always_ff @(posedge clk) begin
      if (rst) sclk_prev_reg <= 1'b1;
      else     sclk_prev_reg <= sclk_s;
   end

   always_ff @(posedge clk) begin
      if (core_rst) begin
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         byte_valid  <= 1'b0;
         rx_byte     <= '0;
         rx_dc       <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         if (cs_s) begin
            bit_cnt_reg <= '0;
         end else if (sclk_rise) begin
            shift_reg <= shift_next;
            if (bit_cnt_reg == 3'd7) begin
               byte_valid  <= 1'b1;
               rx_byte     <= shift_next;
               rx_dc       <= dc_s;
               bit_cnt_reg <= '0;
            end else begin
               bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/ssd1306_spi_receiver.sv
// SSD1306 panel model: command parser, configuration registers and framebuffer write pointers.
module ssd1306_spi_receiver
   import ssd1306_spi_receiver_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FB_ADDR_W   = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 spi_sclk,
   input  logic                 spi_sdin,
   input  logic                 spi_cs,
   input  logic                 spi_dc,
   input  logic                 spi_reset,
   output logic                 fb_we,
   output logic [FB_ADDR_W-1:0] fb_addr,
   output logic [7:0]           fb_data,
   output logic                 display_on,
   output logic [7:0]           contrast,
   output logic                 invert,
   output logic [1:0]           addr_mode,
   output logic                 cmd_err
);

   logic       panel_rst;
   logic       byte_valid;
   logic [7:0] rx_byte;
   logic       rx_dc;
   logic       core_rst;

   spi_byte_rx #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .spi_sclk   (spi_sclk),
      .spi_sdin   (spi_sdin),
      .spi_cs     (spi_cs),
      .spi_dc     (spi_dc),
      .spi_reset  (spi_reset),
      .panel_rst  (panel_rst),
      .byte_valid (byte_valid),
      .rx_byte    (rx_byte),
      .rx_dc      (rx_dc)
   );

   assign core_rst = rst | panel_rst;

   parse_state_t state_reg;
   logic [7:0]   opcode_reg;
   logic [6:0]   col_reg, col_start_reg, col_end_reg;
   logic [2:0]   page_reg, page_start_reg, page_end_reg;
   logic [6:0]   col_next;
   logic [2:0]   page_next;
   logic         col_wrap, page_wrap;

   assign col_wrap  = (col_reg == col_end_reg);
   assign page_wrap = (page_reg == page_end_reg);

   // Pointer position after the current data byte is written.
   always_comb begin
      col_next  = col_reg;
      page_next = page_reg;
      case (addr_mode)
         AM_HORIZ: begin
            if (col_wrap) begin
               col_next  = col_start_reg;
               page_next = page_wrap ? page_start_reg : page_reg + 3'd1;
            end else begin
               col_next  = col_reg + 7'd1;
            end
         end
         AM_VERT: begin
            if (page_wrap) begin
               page_next = page_start_reg;
               col_next  = col_wrap ? col_start_reg : col_reg + 7'd1;
            end else begin
               page_next = page_reg + 3'd1;
            end
         end
         default: col_next = col_wrap ? col_start_reg : col_reg + 7'd1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (core_rst) begin
         state_reg      <= ST_IDLE;
         opcode_reg     <= '0;
         col_reg        <= '0;
         page_reg       <= '0;
         col_start_reg  <= '0;
         col_end_reg    <= COL_END_DEFAULT;
         page_start_reg <= '0;
         page_end_reg   <= PAGE_END_DEFAULT;
         display_on     <= 1'b0;
         contrast       <= CONTRAST_DEFAULT;
         invert         <= 1'b0;
         addr_mode      <= AM_PAGE;
         cmd_err        <= 1'b0;
         fb_we          <= 1'b0;
         fb_addr        <= '0;
         fb_data        <= '0;
      end else begin
         fb_we <= 1'b0;
         if (byte_valid && rx_dc) begin
            // Data abandons any half-received command but is still written.
            if (state_reg != ST_IDLE) cmd_err <= 1'b1;
            state_reg <= ST_IDLE;
            fb_we     <= 1'b1;
            fb_addr   <= FB_ADDR_W'({page_reg, col_reg});
            fb_data   <= rx_byte;
            col_reg   <= col_next;
            page_reg  <= page_next;
         end else if (byte_valid) begin
            case (state_reg)
               ST_IDLE: begin
                  opcode_reg <= rx_byte;
                  case (op_arg_count(rx_byte))
                     2'd0: begin
                        case (rx_byte)
                           OP_DISPLAY_OFF: display_on <= 1'b0;
                           OP_DISPLAY_ON:  display_on <= 1'b1;
                           OP_NORMAL:      invert     <= 1'b0;
                           OP_INVERSE:     invert     <= 1'b1;
                           default: ;
                        endcase
                     end
                     2'd1, 2'd2: state_reg <= ST_ARG1;
                     default:    cmd_err   <= 1'b1;
                  endcase
               end
               ST_ARG1: begin
                  state_reg <= ST_IDLE;
                  case (opcode_reg)
                     OP_CONTRAST:  contrast  <= rx_byte;
                     OP_ADDR_MODE: addr_mode <= rx_byte[1:0];
                     OP_COL_ADDR: begin
                        col_start_reg <= rx_byte[6:0];
                        state_reg     <= ST_ARG2;
                     end
                     OP_PAGE_ADDR: begin
                        page_start_reg <= rx_byte[2:0];
                        state_reg      <= ST_ARG2;
                     end
                     default: ;
                  endcase
               end
               ST_ARG2: begin
                  state_reg <= ST_IDLE;
                  if (opcode_reg == OP_COL_ADDR) begin
                     col_end_reg <= rx_byte[6:0];
                     col_reg     <= col_start_reg;
                  end else begin
                     page_end_reg <= rx_byte[2:0];
                     page_reg     <= page_start_reg;
                  end
               end
               default: state_reg <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
// Self-checking bench: drives SPI bytes and compares against a byte-level behavioural panel model.
`timescale 1ns/1ps
module tb_ssd1306_spi_receiver;

   localparam int SYNC_STAGES = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       spi_sclk = 1'b1;
   logic       spi_sdin = 1'b0;
   logic       spi_cs = 1'b1;
   logic       spi_dc = 1'b0;
   logic       spi_reset = 1'b1;
   logic       fb_we;
   logic [9:0] fb_addr;
   logic [7:0] fb_data;
   logic       display_on;
   logic [7:0] contrast;
   logic       invert;
   logic [1:0] addr_mode;
   logic       cmd_err;

   ssd1306_spi_receiver #(
      .SYNC_STAGES (SYNC_STAGES),
      .FB_ADDR_W   (10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .spi_sclk   (spi_sclk),
      .spi_sdin   (spi_sdin),
      .spi_cs     (spi_cs),
      .spi_dc     (spi_dc),
      .spi_reset  (spi_reset),
      .fb_we      (fb_we),
      .fb_addr    (fb_addr),
      .fb_data    (fb_data),
      .display_on (display_on),
      .contrast   (contrast),
      .invert     (invert),
      .addr_mode  (addr_mode),
      .cmd_err    (cmd_err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int half = 4;
   int last_rise_cyc = 0;
   int last_we_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [9:0] obs_addr_q [$];
   logic [7:0] obs_data_q [$];
   int         exp_addr_q [$];
   int         exp_data_q [$];

   always @(negedge clk) begin
      if (fb_we === 1'b1) begin
         obs_addr_q.push_back(fb_addr);
         obs_data_q.push_back(fb_data);
         last_we_cyc = cyc;
      end
   end

   // ---------------- behavioural panel model ----------------
   int m_display_on, m_contrast, m_invert, m_addr_mode, m_cmd_err;
   int m_col, m_page, m_cs, m_ce, m_ps, m_pe;
   logic [7:0] cmd_q [$];

   function automatic int nargs(input logic [7:0] op);
      if (op inside {8'hAE, 8'hAF, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA0, 8'hA1, 8'hC0, 8'hC8}) return 0;
      if (op >= 8'h40 && op <= 8'h7F) return 0;
      if (op inside {8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB, 8'h8D}) return 1;
      if (op == 8'h21 || op == 8'h22) return 2;
      return -1;
   endfunction

   task automatic model_reset();
      m_display_on = 0; m_contrast = 127; m_invert = 0; m_addr_mode = 2; m_cmd_err = 0;
      m_col = 0; m_page = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
      cmd_q.delete();
   endtask

   task automatic model_apply();
      case (cmd_q[0])
         8'hAE: m_display_on = 0;
         8'hAF: m_display_on = 1;
         8'hA6: m_invert = 0;
         8'hA7: m_invert = 1;
         8'h81: m_contrast = int'(cmd_q[1]);
         8'h20: m_addr_mode = int'(cmd_q[1]) % 4;
         8'h21: begin m_cs = int'(cmd_q[1]) % 128; m_ce = int'(cmd_q[2]) % 128; m_col = m_cs; end
         8'h22: begin m_ps = int'(cmd_q[1]) % 8; m_pe = int'(cmd_q[2]) % 8; m_page = m_ps; end
         default: ;
      endcase
   endtask

   task automatic model_byte(input bit dc, input logic [7:0] b);
      if (dc) begin
         if (cmd_q.size() != 0) begin m_cmd_err = 1; cmd_q.delete(); end
         exp_addr_q.push_back(m_page * 128 + m_col);
         exp_data_q.push_back(int'(b));
         if (m_addr_mode == 1) begin
            if (m_page == m_pe) begin
               m_page = m_ps;
               m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
            end else m_page = (m_page + 1) % 8;
         end else begin
            if (m_col == m_ce) begin
               m_col = m_cs;
               if (m_addr_mode == 0) m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
            end else m_col = (m_col + 1) % 128;
         end
      end else if (cmd_q.size() == 0 && nargs(b) < 0) begin
         m_cmd_err = 1;
      end else begin
         cmd_q.push_back(b);
         if (cmd_q.size() == nargs(cmd_q[0]) + 1) begin
            model_apply();
            cmd_q.delete();
         end
      end
   endtask

   // ---------------- stimulus ----------------
   task automatic send_byte(input bit dc, input logic [7:0] b, input bit cs_after);
      spi_cs = 1'b0;
      spi_dc = dc;
      for (int i = 7; i >= 0; i--) begin
         spi_sclk = 1'b0;
         spi_sdin = b[i];
         repeat (half) @(negedge clk);
         spi_sclk = 1'b1;
         if (i == 0) last_rise_cyc = cyc;
         if (i == 0 && cs_after) begin
            @(negedge clk);
            spi_cs = 1'b1;
            repeat (half - 1) @(negedge clk);
         end else begin
            repeat (half) @(negedge clk);
         end
      end
      model_byte(dc, b);
   endtask

   task automatic settle();
      repeat (8) @(negedge clk);
   endtask

   logic [7:0] init_seq [23] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                                 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'h81, 8'h7F,
                                 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
   logic [7:0] op0_tab [8]     = '{8'hAE, 8'hAF, 8'hA6, 8'hA7, 8'hA4, 8'hA0, 8'hC8, 8'h5A};
   logic [7:0] op_arg_tab [8]  = '{8'h81, 8'h20, 8'h21, 8'h22, 8'hA8, 8'hD3, 8'hD5, 8'h8D};
   logic [7:0] unk_tab [4]     = '{8'hDA, 8'h00, 8'hFF, 8'h2E};
   int         win_addr [6]    = '{'h10A, 'h10B, 'h18A, 'h18B, 'h10A, 'h10B};

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      tests++; if (display_on !== 1'b0) begin fails++; $display("FAIL reset_display_on got %0b exp 0", display_on); end
      tests++; if (contrast !== 8'h7F) begin fails++; $display("FAIL reset_contrast got %h exp 7f", contrast); end
      tests++; if (invert !== 1'b0) begin fails++; $display("FAIL reset_invert got %0b exp 0", invert); end
      tests++; if (addr_mode !== 2'b10) begin fails++; $display("FAIL reset_addr_mode got %b exp 10", addr_mode); end
      tests++; if (cmd_err !== 1'b0) begin fails++; $display("FAIL reset_cmd_err got %0b exp 0", cmd_err); end
      tests++; if (fb_we !== 1'b0 || fb_addr !== 10'd0 || fb_data !== 8'd0) begin
         fails++; $display("FAIL reset_fb got we=%0b addr=%h data=%h exp 0/0/0", fb_we, fb_addr, fb_data);
      end
      $display("[TB] reset checked");
   endtask

   task automatic test_init();
      half = 4;
      for (int i = 0; i < 23; i++) send_byte(1'b0, init_seq[i], 1'b0);
      settle();
      tests++; if (display_on !== 1'b1) begin fails++; $display("FAIL init_display_on got %0b exp 1", display_on); end
      tests++; if (contrast !== 8'h7F) begin fails++; $display("FAIL init_contrast got %h exp 7f", contrast); end
      tests++; if (addr_mode !== 2'b00) begin fails++; $display("FAIL init_addr_mode got %b exp 00", addr_mode); end
      tests++; if (invert !== 1'b0) begin fails++; $display("FAIL init_invert got %0b exp 0", invert); end
      tests++; if (cmd_err !== 1'b0) begin fails++; $display("FAIL init_cmd_err got %0b exp 0", cmd_err); end
      tests++; if (obs_addr_q.size() != 0) begin fails++; $display("FAIL init_writes got %0d exp 0", obs_addr_q.size()); end
      $display("[TB] init stream of 23 bytes checked");
   endtask

   task automatic test_bulk();
      int ea;
      half = 3;
      obs_addr_q.delete(); obs_data_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
      for (int i = 0; i < 1025; i++) send_byte(1'b1, 8'(i % 256), 1'b0);
      settle();
      tests++; if (obs_addr_q.size() != 1025) begin fails++; $display("FAIL bulk_count got %0d exp 1025", obs_addr_q.size()); end
      for (int i = 0; i < 1025 && obs_addr_q.size() > 0; i++) begin
         ea = i % 1024;
         tests++;
         if (obs_addr_q[0] !== 10'(ea) || obs_data_q[0] !== 8'(i % 256) ||
             exp_addr_q[0] != ea) begin
            fails++;
            $display("FAIL bulk_write[%0d] got addr=%h data=%h exp addr=%h data=%h", i,
                     obs_addr_q[0], obs_data_q[0], ea, i % 256);
         end
         void'(obs_addr_q.pop_front()); void'(obs_data_q.pop_front());
         void'(exp_addr_q.pop_front()); void'(exp_data_q.pop_front());
      end
      $display("[TB] bulk 1025 data bytes checked");
   endtask

   task automatic test_window();
      logic [7:0] d [6];
      obs_addr_q.delete(); obs_data_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
      send_byte(1'b0, 8'h21, 1'b0); send_byte(1'b0, 8'h0A, 1'b0); send_byte(1'b0, 8'h0B, 1'b0);
      send_byte(1'b0, 8'h22, 1'b0); send_byte(1'b0, 8'h02, 1'b0); send_byte(1'b0, 8'h03, 1'b0);
      for (int i = 0; i < 6; i++) begin
         d[i] = 8'($urandom);
         send_byte(1'b1, d[i], (i == 5));
      end
      settle();
      tests++; if (obs_addr_q.size() != 6) begin fails++; $display("FAIL window_count got %0d exp 6", obs_addr_q.size()); end
      for (int i = 0; i < 6 && obs_addr_q.size() > 0; i++) begin
         tests++;
         if (obs_addr_q[0] !== 10'(win_addr[i]) || obs_data_q[0] !== d[i]) begin
            fails++;
            $display("FAIL window_write[%0d] got addr=%h data=%h exp addr=%h data=%h", i,
                     obs_addr_q[0], obs_data_q[0], win_addr[i], d[i]);
         end
         void'(obs_addr_q.pop_front()); void'(obs_data_q.pop_front());
      end
      exp_addr_q.delete(); exp_data_q.delete();
      $display("[TB] column/page window checked");
   endtask

   task automatic test_partial();
      logic [7:0] b;
      b = 8'hA7;
      spi_cs = 1'b0;
      for (int i = 7; i >= 3; i--) begin
         spi_sclk = 1'b0; spi_sdin = b[i];
         repeat (half) @(negedge clk);
         spi_sclk = 1'b1;
         repeat (half) @(negedge clk);
      end
      spi_cs = 1'b1;
      repeat (4) @(negedge clk);
      send_byte(1'b0, 8'hA6, 1'b1);
      settle();
      tests++; if (invert !== 1'b0) begin fails++; $display("FAIL partial_invert got %0b exp 0", invert); end
      tests++; if (cmd_err !== 1'b0) begin fails++; $display("FAIL partial_cmd_err got %0b exp 0", cmd_err); end
      tests++; if (obs_addr_q.size() != 0) begin fails++; $display("FAIL partial_writes got %0d exp 0", obs_addr_q.size()); end
      send_byte(1'b0, 8'hA7, 1'b0);
      settle();
      tests++; if (invert !== 1'(m_invert)) begin fails++; $display("FAIL partial_realign got %0b exp %0d", invert, m_invert); end
      send_byte(1'b0, 8'hA6, 1'b1);
      settle();
      tests++; if (invert !== 1'(m_invert)) begin fails++; $display("FAIL partial_restore got %0b exp %0d", invert, m_invert); end
      $display("[TB] partial byte on cs release checked");
   endtask

   task automatic test_mid_arg();
      int ea;
      obs_addr_q.delete(); obs_data_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
      send_byte(1'b0, 8'h81, 1'b0);
      send_byte(1'b1, 8'h55, 1'b0);
      settle();
      tests++; if (cmd_err !== 1'b1) begin fails++; $display("FAIL midarg_cmd_err got %0b exp 1", cmd_err); end
      tests++; if (contrast !== 8'h7F) begin fails++; $display("FAIL midarg_contrast got %h exp 7f", contrast); end
      tests++;
      if (obs_addr_q.size() != 1 || exp_addr_q.size() != 1) begin
         fails++; $display("FAIL midarg_count got %0d exp 1", obs_addr_q.size());
      end else begin
         ea = exp_addr_q[0];
         if (obs_data_q[0] !== 8'h55 || obs_addr_q[0] !== 10'(ea)) begin
            fails++; $display("FAIL midarg_write got addr=%h data=%h exp addr=%h data=55", obs_addr_q[0], obs_data_q[0], ea);
         end
      end
      obs_addr_q.delete(); obs_data_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
      $display("[TB] data inside command argument checked");
   endtask

   task automatic test_panel_reset();
      logic [7:0] d;
      spi_cs = 1'b0; spi_dc = 1'b0;
      for (int i = 0; i < 3; i++) begin
         spi_sclk = 1'b0; spi_sdin = 1'b1;
         repeat (half) @(negedge clk);
         spi_sclk = 1'b1;
         repeat (half) @(negedge clk);
      end
      spi_reset = 1'b0;
      repeat (4) @(negedge clk);
      spi_reset = 1'b1;
      repeat (5) @(negedge clk);
      model_reset();
      send_byte(1'b0, 8'hAF, 1'b0);
      settle();
      tests++; if (display_on !== 1'b1) begin fails++; $display("FAIL preset_display_on got %0b exp 1", display_on); end
      tests++; if (contrast !== 8'h7F) begin fails++; $display("FAIL preset_contrast got %h exp 7f", contrast); end
      tests++; if (invert !== 1'b0) begin fails++; $display("FAIL preset_invert got %0b exp 0", invert); end
      tests++; if (addr_mode !== 2'b10) begin fails++; $display("FAIL preset_addr_mode got %b exp 10", addr_mode); end
      tests++; if (cmd_err !== 1'b0) begin fails++; $display("FAIL preset_cmd_err got %0b exp 0", cmd_err); end
      obs_addr_q.delete(); obs_data_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
      d = 8'($urandom);
      send_byte(1'b1, d, 1'b0);
      settle();
      tests++;
      if (obs_addr_q.size() != 1 || obs_addr_q[0] !== 10'd0 || obs_data_q[0] !== d) begin
         fails++; $display("FAIL preset_write got %0d writes exp 1 at addr 0 data %h", obs_addr_q.size(), d);
      end
      tests++;
      if (last_we_cyc - last_rise_cyc != SYNC_STAGES + 2) begin
         fails++; $display("FAIL latency got %0d exp %0d", last_we_cyc - last_rise_cyc, SYNC_STAGES + 2);
      end
      obs_addr_q.delete(); obs_data_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
      $display("[TB] panel reset mid-byte and fb_we latency checked");
   endtask

   task automatic test_random();
      int r, k, n_w;
      bit csa;
      logic [7:0] op;
      obs_addr_q.delete(); obs_data_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
      for (int n = 0; n < 90; n++) begin
         r = $urandom_range(0, 99);
         csa = ($urandom_range(0, 3) == 0);
         if (r < 45) send_byte(1'b1, 8'($urandom), csa);
         else if (r < 50) send_byte(1'b0, unk_tab[$urandom_range(0, 3)], csa);
         else if (r < 70) send_byte(1'b0, op0_tab[$urandom_range(0, 7)], csa);
         else begin
            k = $urandom_range(0, 7);
            op = op_arg_tab[k];
            send_byte(1'b0, op, csa);
            if ($urandom_range(0, 9) != 0) begin
               case (op)
                  8'h20: send_byte(1'b0, 8'($urandom_range(0, 3)), csa);
                  8'h21: begin
                     send_byte(1'b0, 8'($urandom_range(0, 127)), csa);
                     send_byte(1'b0, 8'($urandom_range(0, 127)), csa);
                  end
                  8'h22: begin
                     send_byte(1'b0, 8'($urandom_range(0, 7)), csa);
                     send_byte(1'b0, 8'($urandom_range(0, 7)), csa);
                  end
                  default: send_byte(1'b0, 8'($urandom), csa);
               endcase
            end
         end
      end
      settle();
      tests++; if (display_on !== 1'(m_display_on)) begin fails++; $display("FAIL rand_display_on got %0b exp %0d", display_on, m_display_on); end
      tests++; if (contrast !== 8'(m_contrast)) begin fails++; $display("FAIL rand_contrast got %h exp %h", contrast, m_contrast); end
      tests++; if (invert !== 1'(m_invert)) begin fails++; $display("FAIL rand_invert got %0b exp %0d", invert, m_invert); end
      tests++; if (addr_mode !== 2'(m_addr_mode)) begin fails++; $display("FAIL rand_addr_mode got %b exp %0d", addr_mode, m_addr_mode); end
      tests++; if (cmd_err !== 1'(m_cmd_err)) begin fails++; $display("FAIL rand_cmd_err got %0b exp %0d", cmd_err, m_cmd_err); end
      tests++;
      if (obs_addr_q.size() != exp_addr_q.size()) begin
         fails++; $display("FAIL rand_count got %0d exp %0d", obs_addr_q.size(), exp_addr_q.size());
      end
      n_w = 0;
      while (obs_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
         tests++;
         if (obs_addr_q[0] !== 10'(exp_addr_q[0]) || obs_data_q[0] !== 8'(exp_data_q[0])) begin
            fails++;
            $display("FAIL rand_write[%0d] got addr=%h data=%h exp addr=%h data=%h", n_w,
                     obs_addr_q[0], obs_data_q[0], exp_addr_q[0], exp_data_q[0]);
         end
         void'(obs_addr_q.pop_front()); void'(obs_data_q.pop_front());
         void'(exp_addr_q.pop_front()); void'(exp_data_q.pop_front());
         n_w++;
      end
      $display("[TB] random mix of 90 operations checked, %0d writes", n_w);
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_init();
      test_bulk();
      test_window();
      test_partial();
      test_mid_arg();
      test_panel_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
